// File: rtl/arb_mux_nx1.sv
// arb_mux_nx1: N-way valid/ready mux, fixed or round-robin arbitration, registered output.
// Optional ARB_MUX_LOCK_EN adds lock_in to pin grants to the last granted channel.
module arb_mux_nx1 #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                             clock_in,
  input  logic                             reset_in,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data_in,
  input  logic [NUM_INPUTS-1:0]            in_valid_in,
  output logic [NUM_INPUTS-1:0]            in_ready_out,
  input  logic                             mode_in,
  input  logic [SEL_WIDTH-1:0]             sel_in,
`ifdef ARB_MUX_LOCK_EN
  input  logic                             lock_in,
`endif
  output logic [DATA_WIDTH-1:0]            out_data_out,
  output logic                             out_valid_out,
  input  logic                             out_ready_in,
  output logic [SEL_WIDTH-1:0]             out_src_out
);

  localparam logic [SEL_WIDTH-1:0] LAST =
    SEL_WIDTH'(NUM_INPUTS - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_WIDTH-1:0] ch [NUM_INPUTS];

  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] fix_idx;
  logic [SEL_WIDTH-1:0] rr_idx;
  logic [SEL_WIDTH-1:0] win_idx;
  logic [SEL_WIDTH-1:0] ptr_nxt;
  logic                 rr_hit;
  logic                 win_hit;
  logic                 can_load;
  logic                 xfer;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
    assign ch[g] = in_data_in[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Out-of-range select codes clamp to the top channel.
  if (NUM_INPUTS == (1 << SEL_WIDTH)) begin : g_fix_full
    assign fix_idx = sel_in;
  end else begin : g_fix_clamp
    assign fix_idx = (sel_in > LAST) ? LAST : sel_in;
  end

  // Scan from the highest offset down so the nearest valid channel wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      automatic int j = (int'(ptr) + k) % NUM_INPUTS;
      if (in_valid_in[j]) begin
        rr_hit = 1'b1;
        rr_idx = SEL_WIDTH'(j);
      end
    end
  end

`ifdef ARB_MUX_LOCK_EN
  logic [SEL_WIDTH-1:0] last_idx;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      last_idx <= '0;
    end else if (xfer) begin
      last_idx <= win_idx;
    end
  end
`endif

  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
`ifdef ARB_MUX_LOCK_EN
    if (lock_in) begin
      win_idx = last_idx;
      win_hit = in_valid_in[last_idx];
    end else
`endif
    if (mode_in) begin
      win_idx = rr_idx;
      win_hit = rr_hit;
    end else begin
      win_idx = fix_idx;
      win_hit = in_valid_in[fix_idx];
    end
  end

  assign can_load = (state == EMPTY) || out_ready_in;

  always_comb begin
    in_ready_out = '0;
    if (can_load && win_hit && !reset_in) begin
      in_ready_out[win_idx] = 1'b1;
    end
  end

  assign xfer = |in_ready_out;

  assign ptr_nxt = (win_idx == LAST) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (xfer) state_nxt = FULL;
      end
      FULL: begin
        if (out_ready_in && !xfer) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid_out = (state == FULL);
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      out_data_out <= '0;
      out_src_out  <= '0;
    end else if (xfer) begin
      out_data_out <= ch[win_idx];
      out_src_out  <= win_idx;
    end
  end

  // Only round-robin transfers move the pointer.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      ptr <= '0;
    end else if (xfer && mode_in) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_arb_mux_nx1.sv
// Directed bench for arb_mux_nx1: fixed select, round-robin, backpressure,
// sparse wrap, async reset, and lock when ARB_MUX_LOCK_EN is defined.
module tb_arb_mux_nx1;

  localparam int W = 16;
  localparam int N = 4;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] din;
  logic [N-1:0]   vld;
  logic [N-1:0]   rdy;
  logic           mode;
  logic [S-1:0]   sel;
  logic [W-1:0]   dout;
  logic           ovld;
  logic           ordy;
  logic [S-1:0]   src;
`ifdef ARB_MUX_LOCK_EN
  logic           lock;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  arb_mux_nx1 #(.DATA_WIDTH(W), .NUM_INPUTS(N)) dut (
    .clock_in     (clk),
    .reset_in     (rst),
    .in_data_in   (din),
    .in_valid_in  (vld),
    .in_ready_out (rdy),
    .mode_in      (mode),
    .sel_in       (sel),
`ifdef ARB_MUX_LOCK_EN
    .lock_in      (lock),
`endif
    .out_data_out (dout),
    .out_valid_out(ovld),
    .out_ready_in (ordy),
    .out_src_out  (src)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic v,
                         input logic [W-1:0] d,
                         input logic [S-1:0] s);
    chk({tag, "_valid"}, 32'(ovld), 32'(v));
    chk({tag, "_data"}, 32'(dout), 32'(d));
    chk({tag, "_src"}, 32'(src), 32'(s));
  endtask

  initial begin
    rst  = 1'b1;
    vld  = '0;
    mode = 1'b0;
    sel  = '0;
    ordy = 1'b0;
`ifdef ARB_MUX_LOCK_EN
    lock = 1'b0;
`endif
    for (int i = 0; i < N; i++) din[i*W +: W] = 16'h1000 + 16'(i);

    // Reset state, ready held low even with demand present
    repeat (2) tick();
    vld  = 4'b1111;
    ordy = 1'b1;
    #1;
    chk_out("reset", 1'b0, 16'h0000, 2'd0);
    chk("reset_rdy", 32'(rdy), 32'h0);

    // Fixed select channel 2
    tick();
    rst  = 1'b0;
    sel  = 2'd2;
    #1;
    chk("fix_rdy0", 32'(rdy), 32'b0100);
    tick();
    chk_out("fix_b0", 1'b1, 16'h1002, 2'd2);
    chk("fix_rdy1", 32'(rdy), 32'b0100);
    tick();
    chk_out("fix_b1", 1'b1, 16'h1002, 2'd2);

    // Selected channel idle: drain, data/src hold
    sel = 2'd1;
    vld = 4'b1101;
    #1;
    chk("fix_idle_rdy", 32'(rdy), 32'h0);
    tick();
    chk_out("fix_drain", 1'b0, 16'h1002, 2'd2);

    // Round-robin from pointer 0
    mode = 1'b1;
    vld  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_rdy", 32'(rdy), 32'(1 << (k % 4)));
      tick();
      chk_out("rr_beat", 1'b1, 16'h1000 + 16'(k % 4), 2'(k % 4));
    end

    // Backpressure holds output frozen
    ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rdy", 32'(rdy), 32'h0);
      tick();
      chk_out("bp_hold", 1'b1, 16'h1000, 2'd0);
    end
    ordy = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(rdy), 32'b0010);
    tick();
    chk_out("bp_rel", 1'b1, 16'h1001, 2'd1);

    // Sparse wrap: move ptr to 1, then ch3/ch0 alternate
    vld = 4'b0001;
    #1;
    chk("sp_rdy0", 32'(rdy), 32'b0001);
    tick();
    chk_out("sp_b0", 1'b1, 16'h1000, 2'd0);
    vld = 4'b1001;
    #1;
    chk("sp_rdy1", 32'(rdy), 32'b1000);
    tick();
    chk_out("sp_b1", 1'b1, 16'h1003, 2'd3);
    chk("sp_rdy2", 32'(rdy), 32'b0001);
    tick();
    chk_out("sp_b2", 1'b1, 16'h1000, 2'd0);
    chk("sp_rdy3", 32'(rdy), 32'b1000);
    tick();
    chk_out("sp_b3", 1'b1, 16'h1003, 2'd3);

    // Async reset mid-stream
    rst = 1'b1;
    #1;
    chk_out("mid_rst", 1'b0, 16'h0000, 2'd0);
    chk("mid_rst_rdy", 32'(rdy), 32'h0);
    tick();
    rst = 1'b0;
    vld = 4'b1111;
    #1;
    chk("post_rst_rdy", 32'(rdy), 32'b0001);
    tick();
    chk_out("post_rst", 1'b1, 16'h1000, 2'd0);

`ifdef ARB_MUX_LOCK_EN
    chk("lk_rdy0", 32'(rdy), 32'b0010);
    tick();
    chk_out("lk_b0", 1'b1, 16'h1001, 2'd1);
    lock = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("lk_rdy", 32'(rdy), 32'b0010);
      tick();
      chk_out("lk_beat", 1'b1, 16'h1001, 2'd1);
    end
    lock = 1'b0;
    #1;
    chk("lk_rel_rdy", 32'(rdy), 32'b0100);
    tick();
    chk_out("lk_rel", 1'b1, 16'h1002, 2'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
